// File: rtl/intersection_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_ctrl_if
//  Description : Signal bundle between the intersection sequencer and the
//                lamp heads / pedestrian push-buttons around it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface intersection_ctrl_if;
    logic       ped_req_ns;
    logic       ped_req_ew;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       ped_walk_ns;
    logic       ped_walk_ew;
    logic [7:0] clock;
    logic [2:0] phase;

    // Controller side: takes the push-buttons, drives lamps and status.
    modport master (
        input  ped_req_ns, ped_req_ew,
        output ns_red, ns_yellow, ns_green,
        output ew_red, ew_yellow, ew_green,
        output ped_walk_ns, ped_walk_ew,
        output clock, phase
    );

    // Environment side: drives the push-buttons, observes everything else.
    modport slave (
        output ped_req_ns, ped_req_ew,
        input  ns_red, ns_yellow, ns_green,
        input  ew_red, ew_yellow, ew_green,
        input  ped_walk_ns, ped_walk_ew,
        input  clock, phase
    );
endinterface
`default_nettype wire

// File: rtl/intersection_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_ctrl
//  Description : Two-road traffic-light sequencer (NS/EW) with green, yellow
//                and all-red clearance phases, latched pedestrian requests
//                that shorten the opposing green, and a phase countdown.
//  Revision    : 1.0 - initial release
// ============================================================================
module intersection_ctrl #(
    parameter int GREEN_T  = 60,
    parameter int YELLOW_T = 5,
    parameter int ALLRED_T = 2,
    parameter int PED_T    = 10
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    intersection_ctrl_if.master   bus
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_NS_G = 3'd1;
    localparam logic [2:0] c_ST_NS_Y = 3'd2;
    localparam logic [2:0] c_ST_AR1  = 3'd3;
    localparam logic [2:0] c_ST_EW_G = 3'd4;
    localparam logic [2:0] c_ST_EW_Y = 3'd5;
    localparam logic [2:0] c_ST_AR2  = 3'd6;

    // Counter load values: a phase of T cycles counts T-1 down to 0.
    localparam logic [7:0] c_GREEN_LOAD  = 8'(GREEN_T - 1);
    localparam logic [7:0] c_YELLOW_LOAD = 8'(YELLOW_T - 1);
    localparam logic [7:0] c_ALLRED_LOAD = 8'(ALLRED_T - 1);
    localparam logic [7:0] c_PED_LOAD    = 8'(PED_T - 1);

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic       r_ped_pend_ns;
    logic       r_ped_pend_ew;

    logic       w_cnt_zero;
    logic       w_pend_ns;
    logic       w_pend_ew;
    logic       w_enter_ns_g;
    logic       w_enter_ew_g;

    assign w_cnt_zero = (r_cnt == 8'd0);

    // Pending view includes this cycle's request so a pulse shortens the
    // opposing green on the very next edge, not one cycle later.
    assign w_pend_ns = r_ped_pend_ns | (bus.ped_req_ns & (r_state != c_ST_NS_G));
    assign w_pend_ew = r_ped_pend_ew | (bus.ped_req_ew & (r_state != c_ST_EW_G));

    // Edges that grant a crossing; these clear the matching latch.
    assign w_enter_ns_g = (r_state == c_ST_IDLE) | ((r_state == c_ST_AR2) & w_cnt_zero);
    assign w_enter_ew_g = (r_state == c_ST_AR1) & w_cnt_zero;

    // Phase sequencer, countdown and pedestrian latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= 8'd0;
            r_ped_pend_ns <= 1'b0;
            r_ped_pend_ew <= 1'b0;
        end else begin
            // Clear beats set: a request arriving as its green starts is served.
            r_ped_pend_ns <= w_pend_ns & ~w_enter_ns_g;
            r_ped_pend_ew <= w_pend_ew & ~w_enter_ew_g;

            case (r_state)
                c_ST_IDLE: begin
                    r_state <= c_ST_NS_G;
                    r_cnt   <= c_GREEN_LOAD;
                end
                c_ST_NS_G: begin
                    if (w_cnt_zero) begin
                        r_state <= c_ST_NS_Y;
                        r_cnt   <= c_YELLOW_LOAD;
                    end else if (w_pend_ew && (r_cnt > c_PED_LOAD)) begin
                        r_cnt   <= c_PED_LOAD;
                    end else begin
                        r_cnt   <= r_cnt - 8'd1;
                    end
                end
                c_ST_NS_Y: begin
                    if (w_cnt_zero) begin
                        r_state <= c_ST_AR1;
                        r_cnt   <= c_ALLRED_LOAD;
                    end else begin
                        r_cnt   <= r_cnt - 8'd1;
                    end
                end
                c_ST_AR1: begin
                    if (w_cnt_zero) begin
                        r_state <= c_ST_EW_G;
                        r_cnt   <= c_GREEN_LOAD;
                    end else begin
                        r_cnt   <= r_cnt - 8'd1;
                    end
                end
                c_ST_EW_G: begin
                    if (w_cnt_zero) begin
                        r_state <= c_ST_EW_Y;
                        r_cnt   <= c_YELLOW_LOAD;
                    end else if (w_pend_ns && (r_cnt > c_PED_LOAD)) begin
                        r_cnt   <= c_PED_LOAD;
                    end else begin
                        r_cnt   <= r_cnt - 8'd1;
                    end
                end
                c_ST_EW_Y: begin
                    if (w_cnt_zero) begin
                        r_state <= c_ST_AR2;
                        r_cnt   <= c_ALLRED_LOAD;
                    end else begin
                        r_cnt   <= r_cnt - 8'd1;
                    end
                end
                c_ST_AR2: begin
                    if (w_cnt_zero) begin
                        r_state <= c_ST_NS_G;
                        r_cnt   <= c_GREEN_LOAD;
                    end else begin
                        r_cnt   <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    // Unused code 7: fall back to a safe all-red restart.
                    r_state <= c_ST_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Moore lamp/walk decode straight from the state register.
    assign bus.ns_green    = (r_state == c_ST_NS_G);
    assign bus.ns_yellow   = (r_state == c_ST_NS_Y);
    assign bus.ns_red      = ~((r_state == c_ST_NS_G) | (r_state == c_ST_NS_Y));
    assign bus.ew_green    = (r_state == c_ST_EW_G);
    assign bus.ew_yellow   = (r_state == c_ST_EW_Y);
    assign bus.ew_red      = ~((r_state == c_ST_EW_G) | (r_state == c_ST_EW_Y));
    assign bus.ped_walk_ns = (r_state == c_ST_NS_G);
    assign bus.ped_walk_ew = (r_state == c_ST_EW_G);
    assign bus.clock       = r_cnt;
    assign bus.phase       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_intersection_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intersection_ctrl
//  Description : Self-checking bench for intersection_ctrl: directed vector
//                table, asynchronous reset sequence and a random run against
//                a phase-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_ctrl;

    localparam int GREEN_T  = 60;
    localparam int YELLOW_T = 5;
    localparam int ALLRED_T = 2;
    localparam int PED_T    = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    intersection_ctrl_if bus ();

    intersection_ctrl #(
        .GREEN_T  (GREEN_T),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T),
        .PED_T    (PED_T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One directed step: hold the requests for adv edges, then expect ph/cv.
    typedef struct {
        int         adv;
        logic       rns;
        logic       rew;
        logic [2:0] ph;
        logic [7:0] cv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int adv, logic rns, logic rew, logic [2:0] ph, logic [7:0] cv);
        vec_t v;
        v.adv = adv; v.rns = rns; v.rew = rew; v.ph = ph; v.cv = cv;
        return v;
    endfunction

    // Compare all outputs against the values implied by an expected phase.
    task automatic check(string nm, logic [2:0] ph, logic [7:0] cv);
        logic [7:0]  exp_l;
        logic [7:0]  act_l;
        logic        ng, ny, eg, ey;
        ng = (ph == 3'd1); ny = (ph == 3'd2);
        eg = (ph == 3'd4); ey = (ph == 3'd5);
        exp_l = {!(ng || ny), ny, ng, !(eg || ey), ey, eg, ng, eg};
        act_l = {bus.ns_red, bus.ns_yellow, bus.ns_green,
                 bus.ew_red, bus.ew_yellow, bus.ew_green,
                 bus.ped_walk_ns, bus.ped_walk_ew};
        checks++;
        if (act_l !== exp_l || bus.phase !== ph || bus.clock !== cv) begin
            errors++;
            $display("FAIL %s @%0t: got phase=%0d clock=%0d lamps=%b, expected phase=%0d clock=%0d lamps=%b",
                     nm, $time, bus.phase, bus.clock, act_l, ph, cv, exp_l);
        end
    endtask

    task automatic run_step(int adv, logic rns, logic rew);
        bus.ped_req_ns = rns;
        bus.ped_req_ew = rew;
        repeat (adv) @(negedge clk);
        bus.ped_req_ns = 1'b0;
        bus.ped_req_ew = 1'b0;
    endtask

    // Reference model: an ordered list of phases with durations.
    // m_idx = -1 means idle; otherwise index into the six-phase cycle.
    int m_idx;
    int m_rem;
    bit m_pns;
    bit m_pew;
    int dur [6];

    task automatic model_reset();
        m_idx = -1; m_rem = 0; m_pns = 0; m_pew = 0;
    endtask

    task automatic model_step(bit rns, bit rew);
        bit ens, eew;
        int old;
        old = m_idx;
        ens = m_pns | (rns && m_idx != 0);
        eew = m_pew | (rew && m_idx != 3);
        if (m_idx < 0) begin
            m_idx = 0;
            m_rem = GREEN_T - 1;
        end else if (m_rem == 0) begin
            m_idx = (m_idx + 1) % 6;
            m_rem = dur[m_idx] - 1;
        end else if ((m_idx == 0 && eew) || (m_idx == 3 && ens)) begin
            m_rem = (m_rem > PED_T - 1) ? PED_T - 1 : m_rem - 1;
        end else begin
            m_rem = m_rem - 1;
        end
        if (m_idx == 0 && old != 0) ens = 0;
        if (m_idx == 3 && old != 3) eew = 0;
        m_pns = ens;
        m_pew = eew;
    endtask

    initial begin
        bus.ped_req_ns = 1'b0;
        bus.ped_req_ew = 1'b0;
        dur[0] = GREEN_T; dur[1] = YELLOW_T; dur[2] = ALLRED_T;
        dur[3] = GREEN_T; dur[4] = YELLOW_T; dur[5] = ALLRED_T;

        // Reset release, free-running cycle.
        tbl.push_back(mk( 0, 0, 0, 3'd0,  0));
        tbl.push_back(mk( 1, 0, 0, 3'd1, 59));
        tbl.push_back(mk(59, 0, 0, 3'd1,  0));
        tbl.push_back(mk( 1, 0, 0, 3'd2,  4));
        tbl.push_back(mk( 5, 0, 0, 3'd3,  1));
        tbl.push_back(mk( 2, 0, 0, 3'd4, 59));
        tbl.push_back(mk(60, 0, 0, 3'd5,  4));
        tbl.push_back(mk( 5, 0, 0, 3'd6,  1));
        tbl.push_back(mk( 2, 0, 0, 3'd1, 59));
        // EW pulse at clock=40 shortens NS green to 10 more cycles.
        tbl.push_back(mk(19, 0, 0, 3'd1, 40));
        tbl.push_back(mk( 1, 0, 1, 3'd1,  9));
        tbl.push_back(mk( 9, 0, 0, 3'd1,  0));
        tbl.push_back(mk( 1, 0, 0, 3'd2,  4));
        tbl.push_back(mk( 7, 0, 0, 3'd4, 59));
        tbl.push_back(mk( 1, 0, 0, 3'd4, 58));
        tbl.push_back(mk(58, 0, 0, 3'd4,  0));
        tbl.push_back(mk( 1, 0, 0, 3'd5,  4));
        tbl.push_back(mk( 7, 0, 0, 3'd1, 59));
        // EW pulse at clock=5: no shortening.
        tbl.push_back(mk(54, 0, 0, 3'd1,  5));
        tbl.push_back(mk( 1, 0, 1, 3'd1,  4));
        tbl.push_back(mk( 4, 0, 0, 3'd1,  0));
        tbl.push_back(mk( 1, 0, 0, 3'd2,  4));
        tbl.push_back(mk( 7, 0, 0, 3'd4, 59));
        tbl.push_back(mk( 1, 0, 0, 3'd4, 58));
        tbl.push_back(mk(59, 0, 0, 3'd5,  4));
        tbl.push_back(mk( 7, 0, 0, 3'd1, 59));
        // NS request held through NS green: never latched.
        tbl.push_back(mk(59, 1, 0, 3'd1,  0));
        tbl.push_back(mk( 1, 1, 0, 3'd2,  4));
        tbl.push_back(mk( 7, 0, 0, 3'd4, 59));
        tbl.push_back(mk( 1, 0, 0, 3'd4, 58));
        tbl.push_back(mk(59, 0, 0, 3'd5,  4));
        tbl.push_back(mk( 7, 0, 0, 3'd1, 59));
        // NS pulse in NS_Y, EW pulse in AR1: EW green shortened, EW latch cleared.
        tbl.push_back(mk(60, 0, 0, 3'd2,  4));
        tbl.push_back(mk( 1, 1, 0, 3'd2,  3));
        tbl.push_back(mk( 3, 0, 0, 3'd2,  0));
        tbl.push_back(mk( 1, 0, 0, 3'd3,  1));
        tbl.push_back(mk( 1, 0, 1, 3'd3,  0));
        tbl.push_back(mk( 1, 0, 0, 3'd4, 59));
        tbl.push_back(mk( 1, 0, 0, 3'd4,  9));
        tbl.push_back(mk( 9, 0, 0, 3'd4,  0));
        tbl.push_back(mk( 1, 0, 0, 3'd5,  4));
        tbl.push_back(mk( 7, 0, 0, 3'd1, 59));
        tbl.push_back(mk( 1, 0, 0, 3'd1, 58));

        // Reset held for a few cycles, released away from the rising edge.
        repeat (3) @(negedge clk);
        check("reset_hold", 3'd0, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_step(tbl[i].adv, tbl[i].rns, tbl[i].rew);
            check($sformatf("vec%0d", i), tbl[i].ph, tbl[i].cv);
        end

        // Asynchronous reset in the middle of EW yellow with an NS request latched.
        run_step(126, 0, 0);
        check("pre_rst_ew_y", 3'd5, 8'd4);
        run_step(1, 1, 0);
        check("pre_rst_ew_y2", 3'd5, 8'd3);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 3'd0, 8'd0);
        @(negedge clk);
        check("rst_held", 3'd0, 8'd0);
        rst_n = 1'b1;
        check("rst_release", 3'd0, 8'd0);
        run_step(1, 0, 0);
        check("restart_ns_g", 3'd1, 8'd59);
        run_step(67, 0, 0);
        check("restart_ew_g", 3'd4, 8'd59);
        run_step(1, 0, 0);
        check("latch_cleared", 3'd4, 8'd58);

        // Random requests against the reference model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 2500; c++) begin
            bit rns, rew;
            check("rand", (m_idx < 0) ? 3'd0 : 3'(m_idx + 1), 8'(m_rem));
            rns = ($urandom_range(0, 24) == 0);
            rew = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rns = 1'b1;
                rew = 1'b1;
            end
            bus.ped_req_ns = rns;
            bus.ped_req_ew = rew;
            model_step(rns, rew);
            @(negedge clk);
        end
        bus.ped_req_ns = 1'b0;
        bus.ped_req_ew = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
